// File: rtl/reg_4bits_piso_tx_load_control.sv
// Parallel-in/serial-out transmitter with a carga/listo load handshake.
// It shifts an N-bit word out one bit per reloj cycle and can take back-to-back words without an idle cycle.
module reg_4bits_piso_tx_load_control #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         reloj,
  input  logic         reset,
  input  logic         carga,
  input  logic [N-1:0] In,
  output logic         listo,
  output logic         serie,
  output logic         valido_serie,
  output logic         fin
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [N-1:0]   r_sh, w_sh_nxt, w_sh_adv;
  logic           w_last, w_accept;

  // Every output is decoded from registered state only, so no path runs from carga to listo.
  assign w_last       = (r_state == SHIFT) && (r_cnt == LAST);
  assign listo        = (r_state == IDLE) || w_last;
  assign w_accept     = carga && listo;
  assign fin          = w_last;
  assign valido_serie = (r_state == SHIFT);
  assign serie        = valido_serie && (MSB_FIRST ? r_sh[N-1] : r_sh[0]);
  assign w_sh_adv     = MSB_FIRST ? {r_sh[N-2:0], 1'b0} : {1'b0, r_sh[N-1:1]};

  // Next-state, counter and shift-register update
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = {CW{1'b0}};
          w_sh_nxt    = In;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (w_last) begin
          if (carga) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = {CW{1'b0}};
            w_sh_nxt    = In;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = {CW{1'b0}};
            w_sh_nxt    = {N{1'b0}};
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          w_sh_nxt  = w_sh_adv;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {CW{1'b0}};
        w_sh_nxt    = {N{1'b0}};
      end
    endcase
  end

  // State registers; reset takes priority over any load on the same edge
  always_ff @(posedge reloj) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= {CW{1'b0}};
      r_sh    <= {N{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sh    <= w_sh_nxt;
    end
  end

endmodule

// File: tb/tb_reg_4bits_piso_tx_load_control.sv
// Directed bench for reg_4bits_piso_tx_load_control.
// One instance shifts LSB-first and one shifts MSB-first. Both instances receive the same stimulus.
module tb_reg_4bits_piso_tx_load_control;

  logic       reloj = 1'b0;
  logic       reset = 1'b0;
  logic       carga = 1'b0;
  logic [3:0] In    = 4'h0;
  logic       listo_l, serie_l, valido_l, fin_l;
  logic       listo_m, serie_m, valido_m, fin_m;
  int         checks = 0;
  int         errors = 0;

  reg_4bits_piso_tx_load_control #(.N(4), .MSB_FIRST(1'b0)) dut_lsb (
    .reloj(reloj), .reset(reset), .carga(carga), .In(In),
    .listo(listo_l), .serie(serie_l), .valido_serie(valido_l), .fin(fin_l)
  );

  reg_4bits_piso_tx_load_control #(.N(4), .MSB_FIRST(1'b1)) dut_msb (
    .reloj(reloj), .reset(reset), .carga(carga), .In(In),
    .listo(listo_m), .serie(serie_m), .valido_serie(valido_m), .fin(fin_m)
  );

  always #5 reloj = ~reloj;

  task automatic step();
    @(posedge reloj);
    #1;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Checks the LSB-first instance: serie, valido_serie, fin and listo
  task automatic chk_l(input string tag, input logic s, input logic v, input logic f, input logic l);
    chk({tag, ".serie"}, serie_l, s);
    chk({tag, ".valido"}, valido_l, v);
    chk({tag, ".fin"}, fin_l, f);
    chk({tag, ".listo"}, listo_l, l);
  endtask

  logic [3:0] exp_lsb;
  logic [3:0] exp_msb;
  logic [7:0] exp_b2b;

  initial begin
    // Reset state
    reset = 1'b1; carga = 1'b0; In = 4'h0;
    step();
    chk_l("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst.msb_listo", listo_m, 1'b1);
    reset = 1'b0;
    step();
    chk_l("idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Tests 1 and 2: load 4'b1011. LSB-first gives 1,1,0,1 and MSB-first gives 1,0,1,1.
    exp_lsb = 4'b1011;
    exp_msb = 4'b1101;
    carga = 1'b1; In = 4'b1011;
    step();
    carga = 1'b0; In = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      chk_l($sformatf("t1.c%0d", c + 1), exp_lsb[c], 1'b1, (c == 3), (c == 3));
      chk($sformatf("t2.c%0d.serie", c + 1), serie_m, exp_msb[c]);
      chk($sformatf("t2.c%0d.fin", c + 1), fin_m, (c == 3));
      chk($sformatf("t2.c%0d.valido", c + 1), valido_m, 1'b1);
      if (c < 3) step();
      else ;
    end
    step();
    chk_l("t1.c5", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2.c5.valido", valido_m, 1'b0);

    // Test 3: 4'hA followed by 4'h5 with no gap gives bits 0,1,0,1,1,0,1,0
    exp_b2b = 8'b0101_1010;
    carga = 1'b1; In = 4'hA;
    step();
    carga = 1'b0; In = 4'h0;
    for (int c = 0; c < 8; c++) begin
      chk_l($sformatf("t3.c%0d", c + 1), exp_b2b[c], 1'b1, (c == 3 || c == 7), (c == 3 || c == 7));
      if (c == 3) begin
        carga = 1'b1; In = 4'h5;
      end else begin
        carga = 1'b0; In = 4'h0;
      end
      step();
    end
    chk_l("t3.c9", 1'b0, 1'b0, 1'b0, 1'b1);

    // Test 4: load 4'h0, then hold carga with 4'hF while the word is shifting. The new load is ignored.
    carga = 1'b1; In = 4'h0;
    step();
    In = 4'hF;
    for (int c = 0; c < 4; c++) begin
      chk_l($sformatf("t4.c%0d", c + 1), 1'b0, 1'b1, (c == 3), (c == 3));
      if (c == 2) carga = 1'b0;
      else ;
      if (c < 3) step();
      else ;
    end
    step();
    chk_l("t4.c5", 1'b0, 1'b0, 1'b0, 1'b1);

    // Test 5: reset in cycle 2 of a 4'b1111 word aborts the word
    carga = 1'b1; In = 4'hF;
    step();
    carga = 1'b0;
    chk_l("t5.c1", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_l("t5.c2", 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_l("t5.c3", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("t5.nofin%0d", c), fin_l, 1'b0);
      chk($sformatf("t5.noval%0d", c), valido_l, 1'b0);
    end

    // Test 6: reset and carga on the same edge. No word is accepted.
    reset = 1'b1; carga = 1'b1; In = 4'hF;
    step();
    reset = 1'b0; carga = 1'b0;
    chk_l("t6.c1", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_l("t6.c2", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6.msb_valido", valido_m, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
